// File: rtl/spi_flash_ctrl_pkg.sv
// Shared definitions for the SPI flash command sequencer: opcodes,
// sequencer states, the idle transmit byte and the status byte layout.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_RDSR      = 8'h05;
    localparam logic [7:0] OP_WREN      = 8'h06;
    localparam logic [7:0] OP_WRDI      = 8'h04;
    localparam logic [7:0] OP_RDID      = 8'h9F;

    localparam logic [7:0] TX_IDLE      = 8'hFF;

    typedef enum logic [3:0] {
        IDLE,
        ADDR2,
        ADDR1,
        ADDR0,
        DUMMY,
        FETCH,
        STREAM,
        STATUS,
        ID,
        IGNORE
    } state_t;

    // Status register image: only the write-enable latch is modelled (bit 1).
    function automatic logic [7:0] statusByte(input logic wel);
        return {6'b0, wel, 1'b0};
    endfunction

endpackage

// File: rtl/spi_flash_ctrl_if.sv
// Bus bundle between spi_device / memory read port (host side) and the
// command sequencer (ctrl side).
interface spi_flash_ctrl_if #(
    parameter int ADDR_W = 24
);
    logic              spi_cs;
    logic              spi_rx_strobe;
    logic              spi_rx_cmd;
    logic [7:0]        spi_rx_data;
    logic [7:0]        spi_tx_data;
    logic              spi_tx_ready;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_valid;
    logic [7:0]        mem_rd_data;
    logic              cmd_strobe;
    logic [7:0]        last_cmd;
    logic [23:0]       last_addr;

    modport ctrl (
        input  spi_cs, spi_rx_strobe, spi_rx_cmd, spi_rx_data,
               mem_rd_valid, mem_rd_data,
        output spi_tx_data, spi_tx_ready, mem_rd_req, mem_rd_addr,
               cmd_strobe, last_cmd, last_addr
    );

    modport host (
        output spi_cs, spi_rx_strobe, spi_rx_cmd, spi_rx_data,
               mem_rd_valid, mem_rd_data,
        input  spi_tx_data, spi_tx_ready, mem_rd_req, mem_rd_addr,
               cmd_strobe, last_cmd, last_addr
    );
endinterface

// File: rtl/spi_flash_ctrl_toggle_sync.sv
// Multi-flop synchroniser for a toggle-style strobe, followed by an edge
// detector that yields a registered one-cycle pulse per input toggle.
// Toggle-to-pulse latency is SYNC_STAGES+1 clocks.
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_toggle,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;
    logic                   r_pulse;

    // Shift the raw toggle through the synchroniser chain and flag any change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= '0;
            r_dly   <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_toggle};
            r_dly   <= r_sync[SYNC_STAGES-1];
            r_pulse <= r_sync[SYNC_STAGES-1] ^ r_dly;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/spi_flash_ctrl.sv
// SPI flash command sequencer running on the system clock. Decodes READ,
// RDSR, WREN/WRDI and RDID from spi_device byte strobes and keeps
// spi_tx_data loaded ahead of each byte slot, fetching from the memory port
// with a single-entry prefetch. Optional macro SPI_FAST_READ_EN adds the
// 0B fast-read opcode with one dummy byte.
module spi_flash_ctrl
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W      = 24,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter int          SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    spi_flash_ctrl_if.ctrl bus
);

    logic                   w_rxEv;
    logic                   w_cmdEv;
    logic                   w_csHigh;
    logic                   w_memHit;
    logic [23:0]            w_addrNext;
    logic [23:0]            w_addrPlus1;
    logic [23:0]            w_addrPlus2;

    logic [SYNC_STAGES-1:0] r_csSync;
    state_t                 r_state;
    logic [23:0]            r_addr;
    logic                   r_wel;
    logic [1:0]             r_idIdx;
    logic                   r_fast;
    logic [7:0]             r_txData;
    logic                   r_txReady;
    logic                   r_memRdReq;
    logic [ADDR_W-1:0]      r_memRdAddr;
    logic                   r_pending;
    logic                   r_pfValid;
    logic [7:0]             r_pfData;
    logic                   r_waitDirect;
    logic                   r_cmdStrobe;
    logic [7:0]             r_lastCmd;
    logic [23:0]            r_lastAddr;

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rxSync (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_toggle (bus.spi_rx_strobe),
        .o_pulse  (w_rxEv)
    );

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cmdSync (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_toggle (bus.spi_rx_cmd),
        .o_pulse  (w_cmdEv)
    );

    // Level synchroniser for chip select; resets to deselected.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_csSync <= '1;
        end else begin
            r_csSync <= {r_csSync[SYNC_STAGES-2:0], bus.spi_cs};
        end
    end

    assign w_csHigh    = r_csSync[SYNC_STAGES-1];
    assign w_memHit    = r_pending & bus.mem_rd_valid;
    assign w_addrNext  = {r_addr[15:0], bus.spi_rx_data};
    assign w_addrPlus1 = r_addr + 24'd1;
    assign w_addrPlus2 = r_addr + 24'd2;

    // Command sequencer: cs abort first, then opcode capture, then per-state byte handling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_wel        <= 1'b0;
            r_idIdx      <= '0;
            r_fast       <= 1'b0;
            r_txData     <= TX_IDLE;
            r_txReady    <= 1'b0;
            r_memRdReq   <= 1'b0;
            r_memRdAddr  <= '0;
            r_pending    <= 1'b0;
            r_pfValid    <= 1'b0;
            r_pfData     <= '0;
            r_waitDirect <= 1'b0;
            r_cmdStrobe  <= 1'b0;
            r_lastCmd    <= '0;
            r_lastAddr   <= '0;
        end else begin
            r_memRdReq  <= 1'b0;
            r_cmdStrobe <= 1'b0;
            if (w_csHigh) begin
                r_state      <= IDLE;
                r_txData     <= TX_IDLE;
                r_txReady    <= 1'b0;
                r_pending    <= 1'b0;
                r_pfValid    <= 1'b0;
                r_waitDirect <= 1'b0;
            end else if (w_rxEv && w_cmdEv) begin
                r_lastCmd    <= bus.spi_rx_data;
                r_cmdStrobe  <= 1'b1;
                r_txReady    <= 1'b0;
                r_pending    <= 1'b0;
                r_pfValid    <= 1'b0;
                r_waitDirect <= 1'b0;
                r_fast       <= 1'b0;
                case (bus.spi_rx_data)
                    OP_READ: begin
                        r_state <= ADDR2;
                    end
`ifdef SPI_FAST_READ_EN
                    OP_FAST_READ: begin
                        r_state <= ADDR2;
                        r_fast  <= 1'b1;
                    end
`endif
                    OP_RDSR: begin
                        r_state  <= STATUS;
                        r_txData <= statusByte(r_wel);
                    end
                    OP_WREN: begin
                        r_wel    <= 1'b1;
                        r_state  <= IGNORE;
                        r_txData <= TX_IDLE;
                    end
                    OP_WRDI: begin
                        r_wel    <= 1'b0;
                        r_state  <= IGNORE;
                        r_txData <= TX_IDLE;
                    end
                    OP_RDID: begin
                        r_state  <= ID;
                        r_txData <= JEDEC_ID[23:16];
                        r_idIdx  <= 2'd1;
                    end
                    default: begin
                        r_state  <= IGNORE;
                        r_txData <= TX_IDLE;
                    end
                endcase
            end else begin
                case (r_state)
                    ADDR2: begin
                        if (w_rxEv) begin
                            r_addr  <= w_addrNext;
                            r_state <= ADDR1;
                        end
                    end
                    ADDR1: begin
                        if (w_rxEv) begin
                            r_addr  <= w_addrNext;
                            r_state <= ADDR0;
                        end
                    end
                    ADDR0: begin
                        if (w_rxEv) begin
                            r_addr      <= w_addrNext;
                            r_lastAddr  <= w_addrNext;
                            r_memRdReq  <= 1'b1;
                            r_memRdAddr <= w_addrNext[ADDR_W-1:0];
                            r_pending   <= 1'b1;
                            r_state     <= r_fast ? DUMMY : FETCH;
                        end
                    end
                    DUMMY: begin
                        if (w_memHit) begin
                            r_pfData  <= bus.mem_rd_data;
                            r_pfValid <= 1'b1;
                            r_pending <= 1'b0;
                        end
                        if (w_rxEv) begin
                            r_state <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (r_pfValid || w_memHit) begin
                            r_txData    <= r_pfValid ? r_pfData : bus.mem_rd_data;
                            r_txReady   <= 1'b1;
                            r_pfValid   <= 1'b0;
                            r_memRdReq  <= 1'b1;
                            r_memRdAddr <= w_addrPlus1[ADDR_W-1:0];
                            r_pending   <= 1'b1;
                            r_state     <= STREAM;
                        end
                    end
                    STREAM: begin
                        if (w_rxEv) begin
                            r_addr <= w_addrPlus1;
                            if (r_pfValid || w_memHit) begin
                                r_txData    <= r_pfValid ? r_pfData : bus.mem_rd_data;
                                r_txReady   <= 1'b1;
                                r_pfValid   <= 1'b0;
                                r_memRdReq  <= 1'b1;
                                r_memRdAddr <= w_addrPlus2[ADDR_W-1:0];
                                r_pending   <= 1'b1;
                            end else begin
                                r_txReady    <= 1'b0;
                                r_waitDirect <= 1'b1;
                            end
                        end else if (w_memHit) begin
                            if (r_waitDirect) begin
                                r_txData     <= bus.mem_rd_data;
                                r_txReady    <= 1'b1;
                                r_waitDirect <= 1'b0;
                                r_memRdReq   <= 1'b1;
                                r_memRdAddr  <= w_addrPlus1[ADDR_W-1:0];
                            end else begin
                                r_pfData  <= bus.mem_rd_data;
                                r_pfValid <= 1'b1;
                                r_pending <= 1'b0;
                            end
                        end
                    end
                    STATUS: begin
                        if (w_rxEv) begin
                            r_txData <= statusByte(r_wel);
                        end
                    end
                    ID: begin
                        if (w_rxEv) begin
                            case (r_idIdx)
                                2'd1: begin
                                    r_txData <= JEDEC_ID[15:8];
                                    r_idIdx  <= 2'd2;
                                end
                                2'd2: begin
                                    r_txData <= JEDEC_ID[7:0];
                                    r_idIdx  <= 2'd3;
                                end
                                default: begin
                                    r_txData <= 8'h00;
                                    r_idIdx  <= 2'd3;
                                end
                            endcase
                        end
                    end
                    IGNORE: begin
                        r_txData <= TX_IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.spi_tx_data  = r_txData;
    assign bus.spi_tx_ready = r_txReady;
    assign bus.mem_rd_req   = r_memRdReq;
    assign bus.mem_rd_addr  = r_memRdAddr;
    assign bus.cmd_strobe   = r_cmdStrobe;
    assign bus.last_cmd     = r_lastCmd;
    assign bus.last_addr    = r_lastAddr;

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Directed bench for spi_flash_ctrl: READ streaming, address wrap, status,
// RDID, chip-select abort, optional fast read and asynchronous reset.
module tb_spi_flash_ctrl;

    logic clk;
    logic reset_n;

    int          assertCount;
    int          failCount;
    int          strobeCount;
    int          strobeBase;
    int          logBase;
    int          memCnt;
    logic [23:0] memAddr;
    logic        lateInject;
    logic [23:0] reqLog[$];

    spi_flash_ctrl_if #(.ADDR_W(24)) bus ();

    spi_flash_ctrl #(
        .ADDR_W      (24),
        .JEDEC_ID    (24'hEF4018),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: logs each request and answers with addr[7:0] after three clocks.
    initial begin
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = 8'h00;
        memCnt  = 0;
        memAddr = '0;
        forever begin
            @(negedge clk);
            bus.mem_rd_valid = 1'b0;
            if (bus.mem_rd_req === 1'b1) begin
                reqLog.push_back(bus.mem_rd_addr);
                memAddr = bus.mem_rd_addr;
                memCnt  = 3;
            end else if (memCnt > 0) begin
                memCnt = memCnt - 1;
                if (memCnt == 0) begin
                    bus.mem_rd_valid = 1'b1;
                    bus.mem_rd_data  = memAddr[7:0];
                end
            end
            if (lateInject) begin
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_data  = 8'hA5;
                lateInject = 1'b0;
            end
        end
    end

    // Count opcode strobes seen on the bus.
    initial begin
        strobeCount = 0;
        forever begin
            @(negedge clk);
            if (bus.cmd_strobe === 1'b1) strobeCount = strobeCount + 1;
        end
    end

    function automatic logic [31:0] logAt(input int idx);
        if (idx < reqLog.size()) return {8'h00, reqLog[idx]};
        return 32'hDEADBEEF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount = assertCount + 1;
        assert (observed === expected) else begin
            failCount = failCount + 1;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic isCmd);
        @(negedge clk);
        bus.spi_rx_data   = data;
        bus.spi_rx_strobe = ~bus.spi_rx_strobe;
        if (isCmd) bus.spi_rx_cmd = ~bus.spi_rx_cmd;
        repeat (12) @(negedge clk);
    endtask

    task automatic setCs(input logic level);
        @(negedge clk);
        bus.spi_cs = level;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        assertCount   = 0;
        failCount     = 0;
        lateInject    = 1'b0;
        reset_n       = 1'b0;
        bus.spi_cs        = 1'b1;
        bus.spi_rx_strobe = 1'b0;
        bus.spi_rx_cmd    = 1'b0;
        bus.spi_rx_data   = 8'h00;

        repeat (3) @(negedge clk);
        checkOutput("rstTxData", bus.spi_tx_data, 8'hFF);
        checkOutput("rstTxReady", bus.spi_tx_ready, 1'b0);
        checkOutput("rstMemReq", bus.mem_rd_req, 1'b0);
        checkOutput("rstMemAddr", bus.mem_rd_addr, 24'h0);
        checkOutput("rstCmdStrobe", bus.cmd_strobe, 1'b0);
        checkOutput("rstLastCmd", bus.last_cmd, 8'h00);
        checkOutput("rstLastAddr", bus.last_addr, 24'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] READ 03 00 10 00");
        logBase    = reqLog.size();
        strobeBase = strobeCount;
        setCs(1'b0);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h10, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("readLastCmd", bus.last_cmd, 8'h03);
        checkOutput("readLastAddr", bus.last_addr, 24'h001000);
        checkOutput("readTx0", bus.spi_tx_data, 8'h00);
        checkOutput("readReady0", bus.spi_tx_ready, 1'b1);
        applyStimulus(8'hAA, 1'b0);
        checkOutput("readTx1", bus.spi_tx_data, 8'h01);
        applyStimulus(8'hAA, 1'b0);
        checkOutput("readTx2", bus.spi_tx_data, 8'h02);
        checkOutput("readReq0", logAt(logBase), 32'h001000);
        checkOutput("readReq1", logAt(logBase + 1), 32'h001001);
        checkOutput("readReq2", logAt(logBase + 2), 32'h001002);
        checkOutput("readReqCount", reqLog.size() - logBase, 4);
        checkOutput("readStrobes", strobeCount - strobeBase, 1);
        setCs(1'b1);
        checkOutput("csIdleTx", bus.spi_tx_data, 8'hFF);
        checkOutput("csIdleReady", bus.spi_tx_ready, 1'b0);

        $display("[TB] READ with address wrap");
        logBase = reqLog.size();
        setCs(1'b0);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'hFF, 1'b0);
        checkOutput("wrapLastAddr", bus.last_addr, 24'hFFFFFF);
        checkOutput("wrapTxTop", bus.spi_tx_data, 8'hFF);
        checkOutput("wrapReadyTop", bus.spi_tx_ready, 1'b1);
        applyStimulus(8'h55, 1'b0);
        checkOutput("wrapTx0", bus.spi_tx_data, 8'h00);
        applyStimulus(8'h55, 1'b0);
        checkOutput("wrapTx1", bus.spi_tx_data, 8'h01);
        applyStimulus(8'h55, 1'b0);
        checkOutput("wrapTx2", bus.spi_tx_data, 8'h02);
        checkOutput("wrapReq0", logAt(logBase), 32'hFFFFFF);
        checkOutput("wrapReq1", logAt(logBase + 1), 32'h000000);
        checkOutput("wrapReq2", logAt(logBase + 2), 32'h000001);
        setCs(1'b1);

        $display("[TB] WREN / RDSR / WRDI / RDSR");
        setCs(1'b0);
        applyStimulus(8'h06, 1'b1);
        checkOutput("wrenTx", bus.spi_tx_data, 8'hFF);
        setCs(1'b1);
        setCs(1'b0);
        applyStimulus(8'h05, 1'b1);
        checkOutput("rdsrWel1", bus.spi_tx_data, 8'h02);
        applyStimulus(8'h3C, 1'b0);
        checkOutput("rdsrWel1Again", bus.spi_tx_data, 8'h02);
        setCs(1'b1);
        setCs(1'b0);
        applyStimulus(8'h04, 1'b1);
        setCs(1'b1);
        setCs(1'b0);
        applyStimulus(8'h05, 1'b1);
        checkOutput("rdsrWel0", bus.spi_tx_data, 8'h00);
        setCs(1'b1);

        $display("[TB] RDID");
        setCs(1'b0);
        applyStimulus(8'h9F, 1'b1);
        checkOutput("rdid0", bus.spi_tx_data, 8'hEF);
        applyStimulus(8'h00, 1'b0);
        checkOutput("rdid1", bus.spi_tx_data, 8'h40);
        applyStimulus(8'h00, 1'b0);
        checkOutput("rdid2", bus.spi_tx_data, 8'h18);
        applyStimulus(8'h00, 1'b0);
        checkOutput("rdid3", bus.spi_tx_data, 8'h00);
        applyStimulus(8'h00, 1'b0);
        checkOutput("rdid4", bus.spi_tx_data, 8'h00);
        setCs(1'b1);

        $display("[TB] CS abort during address phase");
        setCs(1'b0);
        applyStimulus(8'h06, 1'b1);
        setCs(1'b1);
        logBase = reqLog.size();
        setCs(1'b0);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h12, 1'b0);
        applyStimulus(8'h34, 1'b0);
        setCs(1'b1);
        checkOutput("abortNoReq", reqLog.size() - logBase, 0);
        checkOutput("abortTx", bus.spi_tx_data, 8'hFF);
        setCs(1'b0);
        applyStimulus(8'h05, 1'b1);
        checkOutput("abortRdsr", bus.spi_tx_data, 8'h02);
        setCs(1'b1);
        setCs(1'b0);
        applyStimulus(8'h04, 1'b1);
        lateInject = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("lateValidTx", bus.spi_tx_data, 8'hFF);
        checkOutput("lateValidReady", bus.spi_tx_ready, 1'b0);
        checkOutput("lateValidNoReq", reqLog.size() - logBase, 0);
        setCs(1'b1);

        $display("[TB] FAST_READ 0B 00 00 20 xx");
        logBase = reqLog.size();
        setCs(1'b0);
        applyStimulus(8'h0B, 1'b1);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h77, 1'b0);
        checkOutput("fastLastCmd", bus.last_cmd, 8'h0B);
`ifdef SPI_FAST_READ_EN
        checkOutput("fastTx", bus.spi_tx_data, 8'h20);
        checkOutput("fastReady", bus.spi_tx_ready, 1'b1);
        checkOutput("fastLastAddr", bus.last_addr, 24'h000020);
        checkOutput("fastReq0", logAt(logBase), 32'h000020);
`else
        checkOutput("fastTx", bus.spi_tx_data, 8'hFF);
        checkOutput("fastReady", bus.spi_tx_ready, 1'b0);
        checkOutput("fastNoReq", reqLog.size() - logBase, 0);
`endif
        setCs(1'b1);

        $display("[TB] reset during READ");
        setCs(1'b0);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h40, 1'b0);
        checkOutput("preRstTx", bus.spi_tx_data, 8'h40);
        checkOutput("preRstLastAddr", bus.last_addr, 24'h000040);
        reset_n = 1'b0;
        #1;
        checkOutput("midRstTx", bus.spi_tx_data, 8'hFF);
        checkOutput("midRstReady", bus.spi_tx_ready, 1'b0);
        checkOutput("midRstReq", bus.mem_rd_req, 1'b0);
        checkOutput("midRstLastCmd", bus.last_cmd, 8'h00);
        checkOutput("midRstLastAddr", bus.last_addr, 24'h0);
        repeat (8) @(negedge clk);
        checkOutput("heldRstTx", bus.spi_tx_data, 8'hFF);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
